// File: rtl/wrr_cfg_pkg.sv
// Shared definitions for the WRR weight configuration controller.
//   - Default parameter values for the controller, bank and config interface.
//   - Weight type at the default width, and the reset weight value
//     (1 = plain round-robin).
//   - Controller FSM state encoding.
package wrr_cfg_pkg;

  localparam int NUM_REQ_DEF    = 32;
  localparam int WEIGHT_W_DEF   = 4;
  localparam int ID_W_DEF       = 5;
  localparam int COMMIT_TMO_DEF = 256;

  // Every requester starts with weight 1, i.e. plain round-robin.
  localparam int unsigned WEIGHT_RST = 1;

  typedef logic [WEIGHT_W_DEF-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/wrr_weight_cfg_ctrl_if.sv
// Software-facing configuration port of the WRR weight controller.
//   cfg_valid  : request valid (master -> slave)
//   cfg_ready  : controller can accept a request (slave -> master)
//   cfg_id     : target requester index
//   cfg_weight : weight to write
//   cfg_wr     : request carries a shadow-bank write
//   cfg_commit : request carries a commit (shadow -> active)
// A request is accepted when cfg_valid and cfg_ready are both high at a
// rising clock edge.
interface wrr_weight_cfg_ctrl_if
  import wrr_cfg_pkg::*;
#(
  parameter int ID_W     = ID_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF
);

  logic                cfg_valid;
  logic                cfg_ready;
  logic [ID_W-1:0]     cfg_id;
  logic [WEIGHT_W-1:0] cfg_weight;
  logic                cfg_wr;
  logic                cfg_commit;

  modport master (
    output cfg_valid,
    output cfg_id,
    output cfg_weight,
    output cfg_wr,
    output cfg_commit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_id,
    input  cfg_weight,
    input  cfg_wr,
    input  cfg_commit,
    output cfg_ready
  );

endinterface

// File: rtl/wrr_weight_bank.sv
// Shadow/active weight register pair for the WRR arbiter.
//   clk, rst     : clock and synchronous active-low reset
//   wr_en_i      : write wr_weight_i into shadow[wr_id_i]
//   wr_id_i      : shadow write index (caller guarantees it is in range
//                  whenever wr_en_i is high)
//   wr_weight_i  : shadow write data
//   copy_i       : copy the whole shadow bank into the active bank
//   active_o     : flattened active bank, entry i at [i*WEIGHT_W +: WEIGHT_W]
module wrr_weight_bank
  import wrr_cfg_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int ID_W     = ID_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en_i,
  input  logic [ID_W-1:0]             wr_id_i,
  input  logic [WEIGHT_W-1:0]         wr_weight_i,
  input  logic                        copy_i,
  output logic [NUM_REQ*WEIGHT_W-1:0] active_o
);

  logic [WEIGHT_W-1:0] shadow_q [NUM_REQ];
  logic [WEIGHT_W-1:0] shadow_d [NUM_REQ];
  logic [WEIGHT_W-1:0] active_q [NUM_REQ];
  logic [WEIGHT_W-1:0] active_d [NUM_REQ];

  // The copy takes the registered shadow; the controller never writes and
  // copies in the same cycle, so no write-through path is needed.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_en_i && (wr_id_i == ID_W'(i))) begin
        shadow_d[i] = wr_weight_i;
      end
    end
    if (copy_i) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        shadow_q[i] <= WEIGHT_W'(WEIGHT_RST);
        active_q[i] <= WEIGHT_W'(WEIGHT_RST);
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    active_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      active_o[i*WEIGHT_W +: WEIGHT_W] = active_q[i];
    end
  end

endmodule

// File: rtl/wrr_weight_cfg_ctrl.sv
// Weight configuration controller for the weighted round-robin arbiter.
// Software writes weights into a shadow bank and then commits; the commit
// reaches the active bank only at an arbitration boundary (grant acked or
// no requester active), or after COMMIT_TMO cycles of waiting.
//   clk, rst      : clock and synchronous active-low reset
//   cfg_if        : write/commit request port (valid/ready)
//   arb_req_i     : arbiter request vector (monitored)
//   arb_ack_i     : acknowledge of the current grant (monitored)
//   weights_o     : active weight table, entry i at [i*WEIGHT_W +: WEIGHT_W]
//   weight_upd_o  : one-cycle pulse in the first cycle new weights are visible
//   rd_id_i       : readback index
//   rd_weight_o   : active weight of rd_id_i (0 when out of range)
//   cfg_err_o     : sticky, a write targeted an index >= NUM_REQ
//   cfg_forced_o  : sticky, a commit was applied by timeout
module wrr_weight_cfg_ctrl
  import wrr_cfg_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int WEIGHT_W   = WEIGHT_W_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int COMMIT_TMO = COMMIT_TMO_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  wrr_weight_cfg_ctrl_if.slave        cfg_if,
  input  logic [NUM_REQ-1:0]          arb_req_i,
  input  logic                        arb_ack_i,
  output logic [NUM_REQ*WEIGHT_W-1:0] weights_o,
  output logic                        weight_upd_o,
  input  logic [ID_W-1:0]             rd_id_i,
  output logic [WEIGHT_W-1:0]         rd_weight_o,
  output logic                        cfg_err_o,
  output logic                        cfg_forced_o
);

  localparam int CNT_W = $clog2(COMMIT_TMO + 1);

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             upd_q, err_q, forced_q;
  logic             forced_set;
  logic             ready, apply;
  logic             accept, id_ok, boundary, bank_wr;

  assign accept   = cfg_if.cfg_valid && ready;
  assign id_ok    = int'(cfg_if.cfg_id) < NUM_REQ;
  assign boundary = arb_ack_i || (arb_req_i == '0);
  assign bank_wr  = accept && cfg_if.cfg_wr && id_ok;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The boundary is tested before the timeout, so a
  // boundary in the very cycle the counter expires still counts as a
  // regular (non-forced) commit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    forced_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && cfg_if.cfg_commit) begin
          state_d = PEND;
          cnt_d   = '0;
        end
      end
      PEND: begin
        if (boundary) begin
          state_d = APPLY;
        end else if (cnt_q >= CNT_W'(COMMIT_TMO - 1)) begin
          state_d    = APPLY;
          forced_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      APPLY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    ready = 1'b0;
    apply = 1'b0;
    unique case (state_q)
      IDLE:    ready = 1'b1;
      PEND:    ready = 1'b0;
      APPLY:   apply = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign cfg_if.cfg_ready = ready;

  // weight_upd is registered from APPLY so it lines up with the cycle the
  // bank's active registers first show the copied values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      upd_q    <= apply;
      err_q    <= err_q | (accept && cfg_if.cfg_wr && !id_ok);
      forced_q <= forced_q | forced_set;
    end
  end

  wrr_weight_bank #(
    .NUM_REQ  (NUM_REQ),
    .WEIGHT_W (WEIGHT_W),
    .ID_W     (ID_W)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (bank_wr),
    .wr_id_i     (cfg_if.cfg_id),
    .wr_weight_i (cfg_if.cfg_weight),
    .copy_i      (apply),
    .active_o    (weights_o)
  );

  // Readback mux over in-range entries only; an index >= NUM_REQ matches
  // nothing and reads 0.
  always_comb begin
    rd_weight_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_id_i == ID_W'(i)) begin
        rd_weight_o = weights_o[i*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

  assign weight_upd_o = upd_q;
  assign cfg_err_o    = err_q;
  assign cfg_forced_o = forced_q;

endmodule

// File: tb/tb_wrr_weight_cfg_ctrl.sv
// Directed testbench for wrr_weight_cfg_ctrl.
// dut_a: NUM_REQ=32, COMMIT_TMO=256. dut_b: NUM_REQ=24, COMMIT_TMO=8.
module tb_wrr_weight_cfg_ctrl;

  logic         clk;
  logic         rst;

  logic [31:0]  arb_req_a;
  logic         arb_ack_a;
  logic [127:0] weights_a;
  logic         upd_a;
  logic [4:0]   rd_id_a;
  logic [3:0]   rd_weight_a;
  logic         err_a, forced_a;

  logic [23:0]  arb_req_b;
  logic         arb_ack_b;
  logic [95:0]  weights_b;
  logic         upd_b;
  logic [4:0]   rd_id_b;
  logic [3:0]   rd_weight_b;
  logic         err_b, forced_b;

  logic [3:0]   exp_a [32];
  logic [3:0]   exp_b [24];
  logic [127:0] old_a;
  logic [95:0]  old_b;

  int n_chk;
  int n_err;

  wrr_weight_cfg_ctrl_if #(.ID_W(5), .WEIGHT_W(4)) ifa ();
  wrr_weight_cfg_ctrl_if #(.ID_W(5), .WEIGHT_W(4)) ifb ();

  wrr_weight_cfg_ctrl #(
    .NUM_REQ(32), .WEIGHT_W(4), .ID_W(5), .COMMIT_TMO(256)
  ) dut_a (
    .clk(clk), .rst(rst), .cfg_if(ifa),
    .arb_req_i(arb_req_a), .arb_ack_i(arb_ack_a),
    .weights_o(weights_a), .weight_upd_o(upd_a),
    .rd_id_i(rd_id_a), .rd_weight_o(rd_weight_a),
    .cfg_err_o(err_a), .cfg_forced_o(forced_a)
  );

  wrr_weight_cfg_ctrl #(
    .NUM_REQ(24), .WEIGHT_W(4), .ID_W(5), .COMMIT_TMO(8)
  ) dut_b (
    .clk(clk), .rst(rst), .cfg_if(ifb),
    .arb_req_i(arb_req_b), .arb_ack_i(arb_ack_b),
    .weights_o(weights_b), .weight_upd_o(upd_b),
    .rd_id_i(rd_id_b), .rd_weight_o(rd_weight_b),
    .cfg_err_o(err_b), .cfg_forced_o(forced_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] flat_a();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i*4 +: 4] = exp_a[i];
    return r;
  endfunction

  function automatic logic [95:0] flat_b();
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < 24; i++) r[i*4 +: 4] = exp_b[i];
    return r;
  endfunction

  // Called at a falling edge; the request is accepted at the next rising edge.
  task automatic send_a(input logic wr, input logic cm, input logic [4:0] id, input logic [3:0] w);
    ifa.cfg_valid  = 1'b1;
    ifa.cfg_wr     = wr;
    ifa.cfg_commit = cm;
    ifa.cfg_id     = id;
    ifa.cfg_weight = w;
    @(posedge clk);
    #1;
    ifa.cfg_valid  = 1'b0;
    ifa.cfg_wr     = 1'b0;
    ifa.cfg_commit = 1'b0;
  endtask

  task automatic send_b(input logic wr, input logic cm, input logic [4:0] id, input logic [3:0] w);
    ifb.cfg_valid  = 1'b1;
    ifb.cfg_wr     = wr;
    ifb.cfg_commit = cm;
    ifb.cfg_id     = id;
    ifb.cfg_weight = w;
    @(posedge clk);
    #1;
    ifb.cfg_valid  = 1'b0;
    ifb.cfg_wr     = 1'b0;
    ifb.cfg_commit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    arb_req_a = '0; arb_ack_a = 1'b0; rd_id_a = '0;
    arb_req_b = '0; arb_ack_b = 1'b0; rd_id_b = '0;
    ifa.cfg_valid = 1'b0; ifa.cfg_wr = 1'b0; ifa.cfg_commit = 1'b0;
    ifa.cfg_id = '0; ifa.cfg_weight = '0;
    ifb.cfg_valid = 1'b0; ifb.cfg_wr = 1'b0; ifb.cfg_commit = 1'b0;
    ifb.cfg_id = '0; ifb.cfg_weight = '0;
    for (int i = 0; i < 32; i++) exp_a[i] = 4'd1;
    for (int i = 0; i < 24; i++) exp_b[i] = 4'd1;

    // Test 1: reset state
    repeat (2) @(negedge clk);
    check("rst_ready_a", ifa.cfg_ready, 1);
    check("rst_upd_a", upd_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_forced_a", forced_a, 0);
    check("rst_weights_a", weights_a, {32{4'h1}});
    check("rst_ready_b", ifb.cfg_ready, 1);
    check("rst_err_b", err_b, 0);
    check("rst_forced_b", forced_b, 0);
    check("rst_weights_b", weights_b, {24{4'h1}});
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      rd_id_a = 5'(i);
      #1;
      check($sformatf("rst_rd%0d", i), rd_weight_a, 1);
    end

    // Test 2: write id3=7, id17=0, commit with no requester active
    @(negedge clk);
    send_a(1'b1, 1'b0, 5'd3, 4'd7);
    @(negedge clk);
    send_a(1'b1, 1'b0, 5'd17, 4'd0);
    @(negedge clk);
    rd_id_a = 5'd3;
    #1;
    check("t2_shadow_hidden", rd_weight_a, 1);
    old_a = flat_a();
    exp_a[3] = 4'd7;
    exp_a[17] = 4'd0;
    send_a(1'b0, 1'b1, 5'd0, 4'd0);
    @(negedge clk);
    check("t2_pend_ready", ifa.cfg_ready, 0);
    check("t2_pend_upd", upd_a, 0);
    check("t2_pend_w", weights_a, old_a);
    @(negedge clk);
    check("t2_apply_ready", ifa.cfg_ready, 0);
    check("t2_apply_upd", upd_a, 0);
    check("t2_apply_w", weights_a, old_a);
    @(negedge clk);
    check("t2_upd", upd_a, 1);
    check("t2_w", weights_a, flat_a());
    check("t2_w15_12", weights_a[15:12], 4'd7);
    check("t2_w71_68", weights_a[71:68], 4'd0);
    check("t2_ready", ifa.cfg_ready, 1);
    #1;
    check("t2_rd3", rd_weight_a, 7);
    @(negedge clk);
    check("t2_upd_once", upd_a, 0);

    // Test 3: commit waits for arb_ack
    arb_req_a = 32'h1;
    arb_ack_a = 1'b0;
    old_a = flat_a();
    exp_a[0] = 4'd5;
    send_a(1'b1, 1'b1, 5'd0, 4'd5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("t3_wait%0d_ready", k), ifa.cfg_ready, 0);
      check($sformatf("t3_wait%0d_w", k), weights_a, old_a);
      check($sformatf("t3_wait%0d_upd", k), upd_a, 0);
    end
    arb_ack_a = 1'b1;
    @(negedge clk);
    arb_ack_a = 1'b0;
    check("t3_apply_ready", ifa.cfg_ready, 0);
    check("t3_apply_w", weights_a, old_a);
    @(negedge clk);
    check("t3_upd", upd_a, 1);
    check("t3_w", weights_a, flat_a());
    check("t3_forced", forced_a, 0);
    check("t3_ready", ifa.cfg_ready, 1);

    // Test 4: forced commit on dut_b (COMMIT_TMO=8)
    arb_req_b = 24'hFF_FFFF;
    arb_ack_b = 1'b0;
    old_b = flat_b();
    exp_b[2] = 4'd3;
    send_b(1'b1, 1'b1, 5'd2, 4'd3);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("t4_k%0d_forced", k), forced_b, (k >= 8) ? 1 : 0);
      check($sformatf("t4_k%0d_upd", k), upd_b, (k == 9) ? 1 : 0);
      check($sformatf("t4_k%0d_ready", k), ifb.cfg_ready, (k >= 9) ? 1 : 0);
      check($sformatf("t4_k%0d_w", k), weights_b, (k >= 9) ? flat_b() : old_b);
    end

    // Test 5: out-of-range write combined with commit on dut_b
    arb_req_b = '0;
    send_b(1'b1, 1'b1, 5'd30, 4'd4);
    @(negedge clk);
    check("t5_err", err_b, 1);
    check("t5_pend_ready", ifb.cfg_ready, 0);
    @(negedge clk);
    check("t5_apply_upd", upd_b, 0);
    @(negedge clk);
    check("t5_upd", upd_b, 1);
    check("t5_w", weights_b, flat_b());
    check("t5_forced_sticky", forced_b, 1);
    rd_id_b = 5'd30;
    #1;
    check("t5_rd30", rd_weight_b, 0);
    rd_id_b = 5'd2;
    #1;
    check("t5_rd2", rd_weight_b, 3);
    @(negedge clk);
    check("t5_err_sticky", err_b, 1);

    // Test 6: reset during PEND on dut_a
    arb_req_a = 32'h1;
    arb_ack_a = 1'b0;
    send_a(1'b1, 1'b0, 5'd5, 4'd9);
    @(negedge clk);
    send_a(1'b0, 1'b1, 5'd0, 4'd0);
    @(negedge clk);
    check("t6_pend_ready", ifa.cfg_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) exp_a[i] = 4'd1;
    rd_id_a = 5'd5;
    #1;
    check("t6_rd5", rd_weight_a, 1);
    check("t6_ready", ifa.cfg_ready, 1);
    check("t6_w", weights_a, flat_a());
    check("t6_forced", forced_a, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t6_k%0d_upd", k), upd_a, 0);
      check($sformatf("t6_k%0d_ready", k), ifa.cfg_ready, 1);
    end
    #1;
    check("t6_rd5_late", rd_weight_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
